// File: rtl/rv32i_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle control slice.
// Contents: opcode constants, FSM state enumeration, ALU op class,
// and the alu_control / imm_src / result_src / alu_src encodings.
// The sign-extension unit decodes imm_src with the same IMM_* constants.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT   = 2'b00;
  localparam logic [1:0] RES_RDATA    = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // funct3 values the ALU decoder implements for R-type / I-type ALU ops.
  function automatic logic alu_funct3_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/rv32i_mc_control_alu_decoder.sv
// rv32i_alu_decoder: combinational ALU control decode.
// Ports:
//   alu_op      in  ALU operation class from the FSM (add / sub / funct)
//   funct3      in  instr[14:12]
//   funct7b5    in  instr[30]
//   op5         in  opcode[5], distinguishes R-type from I-type
//   alu_control out 3-bit ALU function select
module rv32i_alu_decoder
  import rv32i_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // instr[30] only selects sub for R-type; addi with bit 30 set stays add
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control.sv
// rv32i_mc_control: multicycle RV32I control unit (Moore FSM).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcode/funct3/funct7b5 latched instruction fields
//   zero                  ALU zero flag, used in S_BRANCH
//   pc_write, adr_src, mem_write, ir_write, reg_write   datapath enables/selects
//   result_src, alu_src_a, alu_src_b, alu_control       datapath mux/ALU selects
//   imm_src               immediate format for the sign-extension unit
//   illegal               one-cycle pulse in S_DECODE for unsupported encodings
module rv32i_mc_control
  import rv32i_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         SUPPORT_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_t  state, state_next;
  alu_op_t alu_op;

  logic pc_update, branch, illegal_s;
  logic mem_write_s, ir_write_s, reg_write_s;
  logic op_known, branch_f3_ok, decode_illegal;

  assign branch_f3_ok = (funct3 == 3'b000) || (SUPPORT_BNE && (funct3 == 3'b001));

  always_comb begin
    op_known = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_OPIMM, OP_BRANCH, OP_JAL: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

  assign decode_illegal = !op_known
                        || (((opcode == OP_RTYPE) || (opcode == OP_OPIMM)) && !alu_funct3_legal(funct3))
                        || ((opcode == OP_BRANCH) && !branch_f3_ok);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= state_t'(RESET_STATE);
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_OPIMM:          state_next = S_EXECI;
          // an unsupported branch condition is dropped rather than executed
          OP_BRANCH:         state_next = branch_f3_ok ? S_BRANCH : S_FETCH;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore outputs
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_OP_ADD;
    case (state)
      S_FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        illegal_s = decode_illegal;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_RDATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low while reset is held, even though the state reads S_FETCH.
  // funct3[0] distinguishes bne from beq, inverting the sense of zero.
  assign pc_write  = rst_n & (pc_update | (branch & (zero ^ funct3[0])));
  assign mem_write = rst_n & mem_write_s;
  assign ir_write  = rst_n & ir_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign illegal   = rst_n & illegal_s;

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  rv32i_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (opcode[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Directed self-checking bench for rv32i_mc_control.
// Output bundle order: pc_write, adr_src, mem_write, ir_write, result_src,
// alu_src_a, alu_src_b, reg_write, alu_control, illegal.
module tb_rv32i_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b010;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int checks = 0;
  int errors = 0;

  rv32i_mc_control #(.RESET_STATE(4'd0), .SUPPORT_BNE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .alu_control(alu_control), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, reg_write, alu_control, illegal};

  //                                     pc  adr mw  ir  res    srcA   srcB   rw  aluc    ill
  localparam logic [14:0] E_FETCH    = {1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,1'b0};
  localparam logic [14:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,1'b0};
  localparam logic [14:0] E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,1'b0,3'b000,1'b0};
  localparam logic [14:0] E_MEMREAD  = {1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,3'b000,1'b0};
  localparam logic [14:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,3'b000,1'b0};
  localparam logic [14:0] E_MEMWRITE = {1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,3'b000,1'b0};
  localparam logic [14:0] E_EXECR    = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b000,1'b0};
  localparam logic [14:0] E_EXECI    = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,1'b0,3'b000,1'b0};
  localparam logic [14:0] E_ALUWB    = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b000,1'b0};
  localparam logic [14:0] E_BRANCH   = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b001,1'b0};
  localparam logic [14:0] E_JAL      = {1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,1'b0,3'b000,1'b0};

  logic [14:0] exp_v [5];

  task automatic test_reset();
    // enables held low while in reset
    #1;
    checks++;
    if ({pc_write, ir_write, mem_write, reg_write, illegal} !== 5'b0) begin
      errors++;
      $display("FAIL reset_enables_low: got %b expected 00000",
               {pc_write, ir_write, mem_write, reg_write, illegal});
    end
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 7'b0000011; funct3 = 3'b010;
    exp_v[0] = E_FETCH; exp_v[1] = E_DECODE; exp_v[2] = E_MEMADR; exp_v[3] = E_MEMREAD;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_first_lw cycle %0d: got %b expected %b", i + 1, obs, exp_v[i]);
      end
    end
    // abandon the load in S_MEMREAD
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_write, ir_write, mem_write, reg_write, adr_src} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_memread: got %b expected 00000",
               {pc_write, ir_write, mem_write, reg_write, adr_src});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== E_FETCH) begin
      errors++;
      $display("FAIL reset_release_fetch: got %b expected %b", obs, E_FETCH);
    end
  endtask

  task automatic test_lw();
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b1;
    exp_v[0] = E_FETCH; exp_v[1] = E_DECODE; exp_v[2] = E_MEMADR;
    exp_v[3] = E_MEMREAD; exp_v[4] = E_MEMWB;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL lw cycle %0d: got %b expected %b", i + 1, obs, exp_v[i]);
      end
      if (i == 1) begin
        checks++;
        if (imm_src !== 2'b00) begin
          errors++;
          $display("FAIL lw_imm_src: got %b expected 00", imm_src);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sw();
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    exp_v[0] = E_FETCH; exp_v[1] = E_DECODE; exp_v[2] = E_MEMADR; exp_v[3] = E_MEMWRITE;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL sw cycle %0d: got %b expected %b", i + 1, obs, exp_v[i]);
      end
      if (i == 1) begin
        checks++;
        if (imm_src !== 2'b01) begin
          errors++;
          $display("FAIL sw_imm_src: got %b expected 01", imm_src);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_branch();
    // {funct3[0], zero, expected pc_write in S_BRANCH}
    logic [2:0] cases [4];
    cases[0] = 3'b011; // beq, zero=1 -> taken
    cases[1] = 3'b000; // beq, zero=0 -> not taken
    cases[2] = 3'b101; // bne, zero=0 -> taken
    cases[3] = 3'b110; // bne, zero=1 -> not taken
    for (int c = 0; c < 4; c++) begin
      opcode = 7'b1100011;
      funct3 = {2'b00, cases[c][2]};
      zero   = cases[c][1];
      exp_v[0] = E_FETCH; exp_v[1] = E_DECODE;
      exp_v[2] = E_BRANCH | {cases[c][0], 14'b0};
      for (int i = 0; i < 3; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        checks++;
        if (obs !== exp_v[i]) begin
          errors++;
          $display("FAIL branch case %0d cycle %0d: got %b expected %b", c, i + 1, obs, exp_v[i]);
        end
        if (i == 1) begin
          checks++;
          if (imm_src !== 2'b10) begin
            errors++;
            $display("FAIL branch_imm_src: got %b expected 10", imm_src);
          end
        end
      end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_alu();
    // {opcode, funct3, funct7b5, expected alu_control}
    logic [13:0] cases [6];
    cases[0] = {7'b0110011, 3'b000, 1'b1, 3'b001}; // sub
    cases[1] = {7'b0010011, 3'b000, 1'b1, 3'b000}; // addi, bit30 set
    cases[2] = {7'b0110011, 3'b111, 1'b0, 3'b010}; // and
    cases[3] = {7'b0110011, 3'b110, 1'b0, 3'b011}; // or
    cases[4] = {7'b0010011, 3'b010, 1'b0, 3'b101}; // slti
    cases[5] = {7'b0110011, 3'b000, 1'b0, 3'b000}; // add
    for (int c = 0; c < 6; c++) begin
      opcode   = cases[c][13:7];
      funct3   = cases[c][6:4];
      funct7b5 = cases[c][3];
      exp_v[0] = E_FETCH; exp_v[1] = E_DECODE;
      exp_v[2] = (opcode[5] ? E_EXECR : E_EXECI) | {11'b0, cases[c][2:0], 1'b0};
      exp_v[3] = E_ALUWB;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        checks++;
        if (obs !== exp_v[i]) begin
          errors++;
          $display("FAIL alu case %0d cycle %0d: got %b expected %b", c, i + 1, obs, exp_v[i]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jal();
    opcode = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    exp_v[0] = E_FETCH; exp_v[1] = E_DECODE; exp_v[2] = E_JAL; exp_v[3] = E_ALUWB;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL jal cycle %0d: got %b expected %b", i + 1, obs, exp_v[i]);
      end
      if (i == 1) begin
        checks++;
        if (imm_src !== 2'b11) begin
          errors++;
          $display("FAIL jal_imm_src: got %b expected 11", imm_src);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    opcode = 7'b0110111; funct3 = 3'b000;
    exp_v[0] = E_FETCH; exp_v[1] = E_DECODE | 15'b1; exp_v[2] = E_FETCH;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL illegal_lui cycle %0d: got %b expected %b", i + 1, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // sw immediately followed by lw: no stray write strobes carry over
    opcode = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 4; i++) @(negedge clk);
    opcode = 7'b0000011;
    exp_v[0] = E_FETCH; exp_v[1] = E_DECODE; exp_v[2] = E_MEMADR;
    exp_v[3] = E_MEMREAD; exp_v[4] = E_MEMWB;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i + 1, obs, exp_v[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_branch();
    test_alu();
    test_jal();
    test_illegal();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rv32i_mc_control.md
Name: rv32i_mc_control

Overview:
- Multicycle control unit for the RV32I datapath.
- Sits directly upstream of the sign-extension unit. It decodes the latched instruction fields and drives imm_src, which that unit consumes together with instr[31:7].
- Sequences each instruction through fetch, decode, execute, memory and writeback, one state per clock.
- Generates every datapath enable and mux select.

Parameters:
- RESET_STATE, 4'd0 (S_FETCH): state entered on reset.
- SUPPORT_BNE, 1: when 1, funct3=001 is decoded as bne; when 0, it is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag, combinational, valid in the S_BRANCH cycle.
- pc_write  out  1  PC load enable (pc_update OR taken branch).
- adr_src  out  1  memory address select: 0 = PC, 1 = result.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  instruction/old-PC register load.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 register.
- alu_src_b  out  2  00 rs2 register, 01 immExt, 10 constant 4.
- imm_src  out  2  00 I, 01 S, 10 B, 11 J; matches the sign-extension unit encoding.
- reg_write  out  1  register file write enable.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  one-cycle pulse in S_DECODE when the opcode/funct3 is unsupported.

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are combinational from state, except:
  - imm_src is decoded from opcode alone.
  - alu_control is decoded from alu_op, funct3, funct7b5 and opcode[5].
  - pc_write depends on zero.
- Async reset → state = S_FETCH. There is no pending-transaction memory: a reset mid-instruction abandons it.
- During reset all enables are 0. At first clock after deassert, the S_FETCH outputs apply.
- States and next-state rules:
  - S_FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=add, result_src=10, pc_write=1. Next: S_DECODE.
  - S_DECODE: alu_src_a=01, alu_src_b=01, alu_op=add (branch target into ALUOut). Next, by opcode:
    - 0000011 or 0100011 → S_MEMADR
    - 0110011 → S_EXECR
    - 0010011 → S_EXECI
    - 1100011 → S_BRANCH
    - 1101111 → S_JAL
    - any other → S_FETCH with illegal=1.
  - S_MEMADR: alu_src_a=10, alu_src_b=01, add. Next: S_MEMREAD for a load, S_MEMWRITE for a store.
  - S_MEMREAD: result_src=00, adr_src=1. Next: S_MEMWB.
  - S_MEMWB: result_src=01, reg_write=1. Next: S_FETCH.
  - S_MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: S_FETCH.
  - S_EXECR: alu_src_a=10, alu_src_b=00, alu_op=funct. Next: S_ALUWB.
  - S_EXECI: alu_src_a=10, alu_src_b=01, alu_op=funct. Next: S_ALUWB.
  - S_ALUWB: result_src=00, reg_write=1. Next: S_FETCH.
  - S_BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00. branch_taken = zero XOR funct3[0]; pc_write=branch_taken. Next: S_FETCH.
  - S_JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next: S_ALUWB.
  - Unencoded state values → S_FETCH, all enables 0.
- imm_src by opcode:
  - load → 00
  - opimm → 00
  - store → 01
  - branch → 10
  - jal → 11
  - else → 00
- ALU decode, alu_op=funct:
  - funct3 000: sub only if opcode[5] & funct7b5 (R-type sub); otherwise add. So addi with instr[30]=1 stays add.
  - funct3 010 → slt.
  - funct3 110 → or.
  - funct3 111 → and.
  - Others → add, with illegal asserted at S_DECODE.
- Legal branch funct3: 000 always; 001 only when SUPPORT_BNE=1.
- Instruction latency:
  - load: 5 cycles
  - store: 4
  - R-type / I-type ALU: 4
  - jal: 4
  - branch: 3
- At most one of mem_write and reg_write is high in any cycle.

Decomposition:
- Shared package rv32i_ctrl_pkg:
  - opcode constants
  - state enumeration
  - alu_control, imm_src, result_src and alu_src encodings.
- The sign-extension unit uses the same imm_src constants.
- One sub-module, rv32i_alu_decoder: combinational alu_op/funct → alu_control. The FSM and the imm_src decode stay in the top.

Test Plan:
- Reset: hold rst_n=0 mid-S_MEMREAD, release → S_FETCH; ir_write=1, pc_write=1, reg_write=0, mem_write=0 on the first cycle.
- lw (opcode 0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles. imm_src=00; reg_write=1 only in cycle 5 with result_src=01.
- sw (0100011): mem_write=1 exactly in cycle 4; imm_src=01; adr_src=1; never reg_write.
- beq (funct3=000) with zero=1 → pc_write=1 in cycle 3; zero=0 → pc_write=0. bne with zero=0 → pc_write=1. imm_src=10.
- R-type funct3=000, funct7b5=1 → alu_control=001. addi funct3=000 with instr[30]=1 → alu_control=000. funct3=111 → 010.
- jal (1101111): imm_src=11; pc_write in S_JAL; reg_write in S_ALUWB with result_src=00. Opcode 0110111 → illegal pulse for 1 cycle, back to S_FETCH.
